// File: rtl/mod5_pkg.sv
// Shared types and arithmetic for the serial mod-5 check transmitter.
// The check field makes the framed stream (data followed by check bits,
// MSB first) an exact multiple of 5.
package mod5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam int CHECK_W = 3;

    // One remainder step of a serial MSB-first mod-5 reduction.
    // 2*rem+bit is at most 9, so a single conditional subtract is enough.
    function automatic logic [2:0] mod5_step(input logic [2:0] rem, input logic b);
        logic [3:0] acc;
        acc = {rem, 1'b0} + {3'b000, b};
        if (acc >= 4'd5) begin
            acc = acc - 4'd5;
        end
        return acc[2:0];
    endfunction

    // Check field for a data remainder r: appending three bits multiplies
    // the data by 8 (== 3 mod 5), so the field must equal 2*r mod 5.
    function automatic logic [CHECK_W-1:0] mod5_check(input logic [2:0] rem);
        logic [CHECK_W-1:0] chk;
        case (rem)
            3'd0:    chk = 3'b000;
            3'd1:    chk = 3'b010;
            3'd2:    chk = 3'b100;
            3'd3:    chk = 3'b001;
            3'd4:    chk = 3'b011;
            default: chk = 3'b000;
        endcase
        return chk;
    endfunction

endpackage

// File: rtl/mod5_step_cell.sv
// Combinational mod-5 remainder cell: next = (2*rem + bit) mod 5.
// Used inside the transmitter and usable as a receiver-side checker.
module mod5_step_cell
    import mod5_pkg::*;
(
    input  logic [2:0] rem_i,
    input  logic       bit_i,
    output logic [2:0] rem_o
);

    // Pure arithmetic step, no state.
    always_comb begin
        rem_o = mod5_step(rem_i, bit_i);
    end

endmodule

// File: rtl/mod5_check_tx.sv
// Serial transmitter: sends a DATA_W-bit word MSB first, then a 3-bit
// check field so the whole frame read as an integer is divisible by 5.
// Valid/ready on both sides; a frame never drops or repeats a bit when
// the sink stalls.
module mod5_check_tx
    import mod5_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              sout_valid,
    input  logic              sout_ready,
    output logic              sout_last
);

    // The shift register carries either the data word or the check field,
    // left-aligned so the bit on the wire is always its MSB.
    localparam int SHIFT_W = (DATA_W > CHECK_W) ? DATA_W : CHECK_W;
    localparam int CNT_W   = $clog2(SHIFT_W);

    localparam logic [CNT_W-1:0] DATA_LAST_CNT  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST_CNT = CNT_W'(CHECK_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

    state_e               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [2:0]           rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sout_q, sout_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;

    logic                 load;
    logic                 xfer;
    logic [2:0]           remNext;
    logic [CHECK_W-1:0]   checkBits;

    // Remainder including the bit currently on the wire; on the last data
    // bit this is the full data word mod 5.
    mod5_step_cell u_step (
        .rem_i (rem_q),
        .bit_i (sout_q),
        .rem_o (remNext)
    );

    assign load      = (state_q == IDLE) && din_valid;
    assign xfer      = valid_q && sout_ready;
    assign checkBits = mod5_check(remNext);

    // State and datapath registers; reset abandons any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Frame sequencing: a phase only advances when its final bit is taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (xfer && (cnt_q == '0)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (xfer && (cnt_q == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath; everything holds
    // unless a word is loaded or a bit is transferred.
    always_comb begin
        shift_d = shift_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        valid_d = valid_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = '0;
                    shift_d[SHIFT_W-1 -: DATA_W] = din;
                    rem_d   = '0;
                    cnt_d   = DATA_LAST_CNT;
                    sout_d  = din[DATA_W-1];
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            DATA: begin
                if (xfer) begin
                    rem_d = remNext;
                    if (cnt_q == '0) begin
                        shift_d = '0;
                        shift_d[SHIFT_W-1 -: CHECK_W] = checkBits;
                        cnt_d  = CHECK_LAST_CNT;
                        sout_d = checkBits[CHECK_W-1];
                    end else begin
                        shift_d = shift_q << 1;
                        cnt_d   = cnt_q - CNT_ONE;
                        sout_d  = shift_q[SHIFT_W-2];
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (cnt_q == '0) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        sout_d  = 1'b0;
                    end else begin
                        shift_d = shift_q << 1;
                        cnt_d   = cnt_q - CNT_ONE;
                        sout_d  = shift_q[SHIFT_W-2];
                        last_d  = (cnt_q == CNT_ONE);
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // din_ready comes from the state register alone, so no input reaches it.
    assign din_ready  = (state_q == IDLE);
    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign sout_last  = last_q;

endmodule

// File: tb/tb_mod5_check_tx.sv
// Bench for mod5_check_tx at DATA_W=8 and DATA_W=32.
// Expected frames come from the divisibility rule: frame = data*8 + c with
// c in 0..4 chosen so the frame is a multiple of 5.
module tb_mod5_check_tx;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic        dv8, dv32;
    logic        sready;
    logic        rdy8, rdy32, so8, so32, sv8, sv32, sl8, sl32;

    logic        sel32;
    logic        mRdy, mSo, mSv, mSl;

    logic [2:0]  chkRem, chkNext;
    logic        chkBit;

    int totalChecks = 0;
    int badChecks   = 0;

    typedef struct {
        logic [7:0]  din;
        logic [63:0] expVal;
    } vec_t;

    vec_t vecs[9];

    mod5_check_tx #(.DATA_W(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .din        (din[7:0]),
        .din_valid  (dv8),
        .din_ready  (rdy8),
        .sout       (so8),
        .sout_valid (sv8),
        .sout_ready (sready),
        .sout_last  (sl8)
    );

    mod5_check_tx #(.DATA_W(32)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (dv32),
        .din_ready  (rdy32),
        .sout       (so32),
        .sout_valid (sv32),
        .sout_ready (sready),
        .sout_last  (sl32)
    );

    // Receiving end of the link: one remainder cell stepped per bit.
    mod5_step_cell chk (
        .rem_i (chkRem),
        .bit_i (chkBit),
        .rem_o (chkNext)
    );

    assign mRdy = sel32 ? rdy32 : rdy8;
    assign mSo  = sel32 ? so32  : so8;
    assign mSv  = sel32 ? sv32  : sv8;
    assign mSl  = sel32 ? sl32  : sl8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] expFrame(input logic [31:0] d, input int w);
        longint unsigned v;
        longint unsigned c;
        v = longint'(d);
        if (w < 32) v = v % (64'd1 << w);
        c = (5 - ((v * 8) % 5)) % 5;
        return v * 8 + c;
    endfunction

    // Sends one word through the selected DUT and collects the frame.
    // Entered and left just after a rising edge.
    task automatic applyStimulus(input int w, input logic [31:0] word,
                                 input logic [63:0] stallMask, input bit randReady,
                                 input bit holdValid, input logic [63:0] expVal,
                                 output int cycles);
        int          waitCnt;
        int          nbits;
        int          stalls;
        bit          done;
        bit          abort;
        bit          prevStall;
        logic        prevSo, prevSl;
        logic [2:0]  rem;
        logic [63:0] stream;

        cycles = 0;
        din    = word;
        dv8    = (w == 8);
        dv32   = (w == 32);
        sready = 1'b1;
        waitCnt = 0;
        @(negedge clk);
        while (!mRdy && waitCnt < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("loadReady", mRdy, 1);
        @(posedge clk); #1;
        if (!holdValid) begin
            dv8  = 1'b0;
            dv32 = 1'b0;
        end

        nbits = 0; stalls = 0; done = 0; abort = 0; prevStall = 0;
        prevSo = 0; prevSl = 0; rem = 3'd0; stream = '0;
        while (!done && !abort && cycles < 400) begin
            sready = randReady ? ($urandom_range(3) != 0)
                               : !(cycles < 64 && stallMask[cycles]);
            if (holdValid) din = $urandom;
            @(negedge clk);
            checkOutput("busyNotReady", mRdy, 0);
            checkOutput("validInFrame", mSv, 1);
            if (!mSv) abort = 1;
            if (prevStall) begin
                checkOutput("stallHoldBit", mSo, prevSo);
                checkOutput("stallHoldLast", mSl, prevSl);
            end
            if (mSv && sready) begin
                stream = {stream[62:0], mSo};
                chkRem = rem;
                chkBit = mSo;
                #1;
                rem = chkNext;
                nbits++;
                checkOutput("lastFlag", mSl, (nbits == w + 3));
                if (nbits == w + 3 || mSl) done = 1;
                prevStall = 0;
            end else begin
                stalls++;
                prevStall = 1;
                prevSo = mSo;
                prevSl = mSl;
            end
            cycles++;
            @(posedge clk); #1;
        end
        dv8  = 1'b0;
        dv32 = 1'b0;
        checkOutput("frameDone", done, 1);
        checkOutput("frameBits", nbits, w + 3);
        checkOutput("frameValue", stream, expVal);
        checkOutput("loopbackRem", rem, 0);
        checkOutput("frameCycles", cycles, w + 3 + stalls);
        @(negedge clk);
        checkOutput("idleReady", mRdy, 1);
        checkOutput("idleValid", mSv, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        logic [31:0] word;

        vecs[0] = '{8'h00, 64'd0};
        vecs[1] = '{8'h07, 64'd60};
        vecs[2] = '{8'h0D, 64'd105};
        vecs[3] = '{8'hFF, 64'd2040};
        vecs[4] = '{8'h01, 64'd10};
        vecs[5] = '{8'h02, 64'd20};
        vecs[6] = '{8'h03, 64'd25};
        vecs[7] = '{8'h0A, 64'd80};
        vecs[8] = '{8'h10, 64'd130};

        rst = 1'b1; din = '0; dv8 = 0; dv32 = 0; sready = 0; sel32 = 0;
        chkRem = 3'd0; chkBit = 1'b0;

        // Outputs while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReady8", rdy8, 1);
        checkOutput("rstValid8", sv8, 0);
        checkOutput("rstLast8", sl8, 0);
        checkOutput("rstBit8", so8, 0);
        checkOutput("rstReady32", rdy32, 1);
        checkOutput("rstValid32", sv32, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of known frames with the sink always ready.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8, {24'd0, vecs[i].din}, 64'd0, 0, 0, vecs[i].expVal, cyc);
            checkOutput("tableCycles", cyc, 11);
        end

        // Stalls: 3 cycles after bit 2, 2 cycles after the first check bit.
        applyStimulus(8, 32'h0D, 64'h0000_0000_0000_3038, 0, 0, 64'd105, cyc);
        checkOutput("stallCycles", cyc, 16);

        // din_valid held with changing din during the frame.
        applyStimulus(8, 32'h5C, 64'd0, 0, 1, 64'd740, cyc);
        applyStimulus(8, 32'h07, 64'd0, 0, 0, 64'd60, cyc);

        // Asynchronous reset while bit 5 of 8'hFE is on the wire.
        din = 32'hFE; dv8 = 1'b1; sready = 1'b1;
        @(negedge clk);
        checkOutput("preRstLoadReady", rdy8, 1);
        @(posedge clk); #1;
        dv8 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checkOutput("preRstValid", sv8, 1);
        checkOutput("preRstBit", so8, 1);
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", sv8, 0);
        checkOutput("midRstLast", sl8, 0);
        checkOutput("midRstBit", so8, 0);
        checkOutput("midRstReady", rdy8, 1);
        @(negedge clk);
        checkOutput("heldRstReady", rdy8, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(8, 32'h04, 64'd0, 0, 0, 64'd35, cyc);
        checkOutput("postRstCycles", cyc, 11);

        // Random words with a randomly stalling sink, both widths.
        for (int w = 8; w <= 32; w += 24) begin
            sel32 = (w == 32);
            for (int i = 0; i < 500; i++) begin
                word = $urandom;
                applyStimulus(w, word, 64'd0, 1, 0, expFrame(word, w), cyc);
            end
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
